// File: rtl/wb_pkg.sv
// Shared encodings, drain FSM states and the lane/row helper for the writeback stage.
package wb_pkg;

  localparam logic [1:0] WB_SRC_MEM  = 2'b11;
  localparam logic       MAT_SRC_MEM = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  // Matrix row carried by a given lane during a given beat.
  function automatic int lane_row(input int beat, input int lane, input int lanes);
    return beat * lanes + lane;
  endfunction

endpackage

// File: rtl/wb_mopa_drain.sv
// MOPA drain: buffers all outer-product rows and fans them out MLANES rows per beat.
// Beat 0 comes straight from the input rows so it lands in the same cycle as the scalar write.
module wb_mopa_drain
  import wb_pkg::*;
#(
  parameter int  XLEN   = 32,
  parameter int  MROWS  = 4,
  parameter int  MLANES = 1,
  localparam int IDXW   = $clog2(MROWS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [MROWS*XLEN-1:0]  rows,
  output logic                   beat_valid,
  output logic [MLANES-1:0]      beat_we,
  output logic [MLANES*IDXW-1:0] beat_idx,
  output logic [MLANES*XLEN-1:0] beat_data,
  output logic                   busy
);

  localparam int BEATS = MROWS / MLANES;
  localparam int CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;

  drain_state_e    state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] row_buf [MROWS];
  logic [IDXW-1:0] row;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      for (int r = 0; r < MROWS; r++) begin
        row_buf[r] <= rows[r*XLEN +: XLEN];
      end
    end
  end

  // cnt_q holds the beat that will be emitted at the next edge; beat 0 is emitted on start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start && (BEATS > 1)) begin
          state_d = DRAIN;
          cnt_d   = CNTW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CNTW'(BEATS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    beat_valid = start || (state_q == DRAIN);
    beat_we    = '0;
    beat_idx   = '0;
    beat_data  = '0;
    row        = '0;
    for (int l = 0; l < MLANES; l++) begin
      if (state_q == DRAIN) begin
        row                       = IDXW'(lane_row(int'(cnt_q), l, MLANES));
        beat_data[l*XLEN +: XLEN] = row_buf[row];
      end else begin
        row                       = IDXW'(l);
        beat_data[l*XLEN +: XLEN] = rows[l*XLEN +: XLEN];
      end
      beat_we[l]                = beat_valid;
      beat_idx[l*IDXW +: IDXW]  = row;
    end
  end

  assign busy = (state_q == DRAIN);

endmodule

// File: rtl/stage_wb_seq.sv
// Registered writeback stage: scalar regfile write plus MLANES-wide matrix row writes,
// with a valid/ready handshake that stalls upstream while a MOPA result drains.
module stage_wb_seq
  import wb_pkg::*;
#(
  parameter int  XLEN   = 32,
  parameter int  MROWS  = 4,
  parameter int  MLANES = 1,
  localparam int IDXW   = $clog2(MROWS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic [4:0]             wb_rd,
  input  logic                   wb_reg_we,
  input  logic [1:0]             wb_mem_matrix2reg,
  input  logic                   wb_mat_we,
  input  logic                   wb_mem_reg2matrix,
  input  logic [IDXW-1:0]        wb_matrix_index,
  input  logic                   wb_mopa,
  input  logic [XLEN-1:0]        wb_mem_data,
  input  logic [XLEN-1:0]        wb_alu_o,
  input  logic [MROWS*XLEN-1:0]  wb_matrix_mul_o,
  output logic                   w_reg_we,
  output logic [4:0]             w_reg_rd,
  output logic [XLEN-1:0]        w_regs_data,
  output logic [MLANES-1:0]      w_mat_we,
  output logic [MLANES*IDXW-1:0] w_mat_idx,
  output logic [MLANES*XLEN-1:0] w_matrix_data,
  output logic                   busy
);

  logic                   accept;
  logic                   mopa_start;
  logic                   drain_busy;
  logic                   beat_valid;
  logic [MLANES-1:0]      beat_we;
  logic [MLANES*IDXW-1:0] beat_idx;
  logic [MLANES*XLEN-1:0] beat_data;

  logic                   reg_we_d;
  logic [4:0]             reg_rd_d;
  logic [XLEN-1:0]        reg_data_d;
  logic [MLANES-1:0]      mat_we_d;
  logic [MLANES*IDXW-1:0] mat_idx_d;
  logic [MLANES*XLEN-1:0] mat_data_d;

  assign wb_ready   = ~drain_busy;
  assign busy       = drain_busy;
  assign accept     = wb_valid & wb_ready;
  assign mopa_start = accept & wb_mopa;

  wb_mopa_drain #(
    .XLEN   (XLEN),
    .MROWS  (MROWS),
    .MLANES (MLANES)
  ) u_drain (
    .clk        (clk),
    .rstn       (rstn),
    .start      (mopa_start),
    .rows       (wb_matrix_mul_o),
    .beat_valid (beat_valid),
    .beat_we    (beat_we),
    .beat_idx   (beat_idx),
    .beat_data  (beat_data),
    .busy       (drain_busy)
  );

  // Writes to x0 are suppressed here so the regfile never sees them.
  always_comb begin
    reg_we_d   = accept & wb_reg_we & (wb_rd != 5'd0);
    reg_rd_d   = '0;
    reg_data_d = '0;
    if (reg_we_d) begin
      reg_rd_d   = wb_rd;
      reg_data_d = (wb_mem_matrix2reg == WB_SRC_MEM) ? wb_mem_data : wb_alu_o;
    end
  end

  // A MOPA beat always takes the matrix port; a single-row request alongside it is dropped.
  always_comb begin
    mat_we_d   = '0;
    mat_idx_d  = '0;
    mat_data_d = '0;
    if (beat_valid) begin
      mat_we_d   = beat_we;
      mat_idx_d  = beat_idx;
      mat_data_d = beat_data;
    end else if (accept && wb_mat_we) begin
      mat_we_d[0]             = 1'b1;
      mat_idx_d[IDXW-1:0]     = wb_matrix_index;
      mat_data_d[XLEN-1:0]    = (wb_mem_reg2matrix == MAT_SRC_MEM) ? wb_mem_data : wb_alu_o;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_reg_we      <= 1'b0;
      w_reg_rd      <= '0;
      w_regs_data   <= '0;
      w_mat_we      <= '0;
      w_mat_idx     <= '0;
      w_matrix_data <= '0;
    end else begin
      w_reg_we      <= reg_we_d;
      w_reg_rd      <= reg_rd_d;
      w_regs_data   <= reg_data_d;
      w_mat_we      <= mat_we_d;
      w_mat_idx     <= mat_idx_d;
      w_matrix_data <= mat_data_d;
    end
  end

endmodule

// File: tb/tb_stage_wb_seq.sv
// Directed bench for stage_wb_seq: one instance with a single matrix lane, one with two lanes.
module tb_stage_wb_seq;

  logic         clk;
  logic         rstn;
  logic         wb_valid1, wb_valid2;
  logic [4:0]   wb_rd;
  logic         wb_reg_we;
  logic [1:0]   wb_mem_matrix2reg;
  logic         wb_mat_we;
  logic         wb_mem_reg2matrix;
  logic [1:0]   wb_matrix_index;
  logic         wb_mopa;
  logic [31:0]  wb_mem_data;
  logic [31:0]  wb_alu_o;
  logic [127:0] wb_matrix_mul_o;

  logic         ready1, reg_we1, busy1;
  logic [4:0]   reg_rd1;
  logic [31:0]  regs_data1;
  logic [0:0]   mat_we1;
  logic [1:0]   mat_idx1;
  logic [31:0]  mat_data1;

  logic         ready2, reg_we2, busy2;
  logic [4:0]   reg_rd2;
  logic [31:0]  regs_data2;
  logic [1:0]   mat_we2;
  logic [3:0]   mat_idx2;
  logic [63:0]  mat_data2;

  int n_checks = 0;
  int n_fail   = 0;

  stage_wb_seq #(.XLEN(32), .MROWS(4), .MLANES(1)) u_dut1 (
    .clk (clk), .rstn (rstn), .wb_valid (wb_valid1), .wb_ready (ready1),
    .wb_rd (wb_rd), .wb_reg_we (wb_reg_we), .wb_mem_matrix2reg (wb_mem_matrix2reg),
    .wb_mat_we (wb_mat_we), .wb_mem_reg2matrix (wb_mem_reg2matrix),
    .wb_matrix_index (wb_matrix_index), .wb_mopa (wb_mopa), .wb_mem_data (wb_mem_data),
    .wb_alu_o (wb_alu_o), .wb_matrix_mul_o (wb_matrix_mul_o),
    .w_reg_we (reg_we1), .w_reg_rd (reg_rd1), .w_regs_data (regs_data1),
    .w_mat_we (mat_we1), .w_mat_idx (mat_idx1), .w_matrix_data (mat_data1), .busy (busy1)
  );

  stage_wb_seq #(.XLEN(32), .MROWS(4), .MLANES(2)) u_dut2 (
    .clk (clk), .rstn (rstn), .wb_valid (wb_valid2), .wb_ready (ready2),
    .wb_rd (wb_rd), .wb_reg_we (wb_reg_we), .wb_mem_matrix2reg (wb_mem_matrix2reg),
    .wb_mat_we (wb_mat_we), .wb_mem_reg2matrix (wb_mem_reg2matrix),
    .wb_matrix_index (wb_matrix_index), .wb_mopa (wb_mopa), .wb_mem_data (wb_mem_data),
    .wb_alu_o (wb_alu_o), .wb_matrix_mul_o (wb_matrix_mul_o),
    .w_reg_we (reg_we2), .w_reg_rd (reg_rd2), .w_regs_data (regs_data2),
    .w_mat_we (mat_we2), .w_mat_idx (mat_idx2), .w_matrix_data (mat_data2), .busy (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    wb_valid1 = 0; wb_valid2 = 0; wb_rd = '0; wb_reg_we = 0; wb_mem_matrix2reg = '0;
    wb_mat_we = 0; wb_mem_reg2matrix = 0; wb_matrix_index = '0; wb_mopa = 0;
    wb_mem_data = '0; wb_alu_o = '0; wb_matrix_mul_o = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (reg_we1 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_reg_we: got %b expected 0", reg_we1); end
    n_checks++; if (mat_we1 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mat_we: got %b expected 0", mat_we1); end
    n_checks++; if (mat_data1 !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_mat_data: got %h expected 0", mat_data1); end
    n_checks++; if (ready1 !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", ready1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy1); end
    n_checks++; if (mat_we2 !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_mat_we2: got %b expected 00", mat_we2); end
    #10;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_scalar_load();
    wb_valid1 = 1; wb_rd = 5'd5; wb_reg_we = 1; wb_mem_matrix2reg = 2'b11;
    wb_mem_data = 32'hDEADBEEF; wb_alu_o = 32'h55;
    tick();
    idle_inputs();
    n_checks++; if (reg_we1 !== 1'b1) begin n_fail++; $display("[TB] FAIL load_we: got %b expected 1", reg_we1); end
    n_checks++; if (reg_rd1 !== 5'd5) begin n_fail++; $display("[TB] FAIL load_rd: got %0d expected 5", reg_rd1); end
    n_checks++; if (regs_data1 !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL load_data: got %h expected deadbeef", regs_data1); end
    n_checks++; if (mat_we1 !== 1'b0) begin n_fail++; $display("[TB] FAIL load_no_mat: got %b expected 0", mat_we1); end
    tick();
    n_checks++; if (reg_we1 !== 1'b0) begin n_fail++; $display("[TB] FAIL load_one_cycle: got %b expected 0", reg_we1); end
    wb_valid1 = 1; wb_rd = 5'd0; wb_reg_we = 1; wb_mem_matrix2reg = 2'b11; wb_mem_data = 32'h1;
    tick();
    idle_inputs();
    n_checks++; if (reg_we1 !== 1'b0) begin n_fail++; $display("[TB] FAIL x0_write: got %b expected 0", reg_we1); end
    wb_valid1 = 1; wb_rd = 5'd7; wb_reg_we = 1; wb_mem_matrix2reg = 2'b01;
    wb_mem_data = 32'hFFFF0000; wb_alu_o = 32'h11112222;
    tick();
    idle_inputs();
    n_checks++; if (regs_data1 !== 32'h11112222) begin n_fail++; $display("[TB] FAIL alu_src_data: got %h expected 11112222", regs_data1); end
    n_checks++; if (reg_rd1 !== 5'd7) begin n_fail++; $display("[TB] FAIL alu_src_rd: got %0d expected 7", reg_rd1); end
  endtask

  task automatic test_single_row();
    wb_valid1 = 1; wb_mat_we = 1; wb_matrix_index = 2'd2; wb_mem_reg2matrix = 0;
    wb_alu_o = 32'h1234; wb_mem_data = 32'h9999;
    tick();
    idle_inputs();
    n_checks++; if (mat_we1 !== 1'b1) begin n_fail++; $display("[TB] FAIL row_we: got %b expected 1", mat_we1); end
    n_checks++; if (mat_idx1 !== 2'd2) begin n_fail++; $display("[TB] FAIL row_idx: got %0d expected 2", mat_idx1); end
    n_checks++; if (mat_data1 !== 32'h1234) begin n_fail++; $display("[TB] FAIL row_data: got %h expected 1234", mat_data1); end
    n_checks++; if (reg_we1 !== 1'b0) begin n_fail++; $display("[TB] FAIL row_no_reg: got %b expected 0", reg_we1); end
    wb_valid1 = 1; wb_mat_we = 1; wb_matrix_index = 2'd1; wb_mem_reg2matrix = 1;
    wb_alu_o = 32'h1234; wb_mem_data = 32'h9999;
    tick();
    idle_inputs();
    n_checks++; if (mat_data1 !== 32'h9999) begin n_fail++; $display("[TB] FAIL row_mem_data: got %h expected 9999", mat_data1); end
    n_checks++; if (mat_idx1 !== 2'd1) begin n_fail++; $display("[TB] FAIL row_mem_idx: got %0d expected 1", mat_idx1); end
    tick();
    n_checks++; if (mat_we1 !== 1'b0) begin n_fail++; $display("[TB] FAIL row_one_cycle: got %b expected 0", mat_we1); end
  endtask

  task automatic test_back_to_back();
    wb_valid1 = 1; wb_mopa = 1; wb_mat_we = 1; wb_matrix_index = 2'd3;
    wb_rd = 5'd9; wb_reg_we = 1; wb_mem_matrix2reg = 2'b00; wb_alu_o = 32'hBAD;
    wb_matrix_mul_o = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    n_checks++; if (ready1 !== 1'b1) begin n_fail++; $display("[TB] FAIL mopa_ready_before: got %b expected 1", ready1); end
    for (int b = 0; b < 4; b++) begin
      tick();
      n_checks++; if (mat_we1 !== 1'b1) begin n_fail++; $display("[TB] FAIL mopa_we beat %0d: got %b expected 1", b, mat_we1); end
      n_checks++; if (mat_idx1 !== 2'(b)) begin n_fail++; $display("[TB] FAIL mopa_idx beat %0d: got %0d expected %0d", b, mat_idx1, b); end
      n_checks++; if (mat_data1 !== 32'(32'hA0 + b)) begin n_fail++; $display("[TB] FAIL mopa_data beat %0d: got %h expected %h", b, mat_data1, 32'hA0 + b); end
      n_checks++; if (ready1 !== (b == 3)) begin n_fail++; $display("[TB] FAIL mopa_ready beat %0d: got %b expected %b", b, ready1, b == 3); end
      n_checks++; if (busy1 !== (b != 3)) begin n_fail++; $display("[TB] FAIL mopa_busy beat %0d: got %b expected %b", b, busy1, b != 3); end
      n_checks++; if (reg_we1 !== (b == 0)) begin n_fail++; $display("[TB] FAIL mopa_scalar beat %0d: got %b expected %b", b, reg_we1, b == 0); end
    end
    wb_mopa = 0; wb_mat_we = 0; wb_rd = 5'd12; wb_reg_we = 1; wb_mem_matrix2reg = 2'b11;
    wb_mem_data = 32'hCAFE0001;
    tick();
    idle_inputs();
    n_checks++; if (reg_we1 !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_we: got %b expected 1", reg_we1); end
    n_checks++; if (reg_rd1 !== 5'd12) begin n_fail++; $display("[TB] FAIL b2b_rd: got %0d expected 12", reg_rd1); end
    n_checks++; if (regs_data1 !== 32'hCAFE0001) begin n_fail++; $display("[TB] FAIL b2b_data: got %h expected cafe0001", regs_data1); end
    n_checks++; if (mat_we1 !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_no_row: got %b expected 0", mat_we1); end
  endtask

  task automatic test_two_lanes();
    wb_valid2 = 1; wb_mopa = 1;
    wb_matrix_mul_o = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    tick();
    idle_inputs();
    n_checks++; if (mat_we2 !== 2'b11) begin n_fail++; $display("[TB] FAIL lanes_we0: got %b expected 11", mat_we2); end
    n_checks++; if (mat_idx2 !== 4'b0100) begin n_fail++; $display("[TB] FAIL lanes_idx0: got %b expected 0100", mat_idx2); end
    n_checks++; if (mat_data2 !== {32'hB1, 32'hB0}) begin n_fail++; $display("[TB] FAIL lanes_data0: got %h expected b1/b0", mat_data2); end
    n_checks++; if (ready2 !== 1'b0) begin n_fail++; $display("[TB] FAIL lanes_ready0: got %b expected 0", ready2); end
    n_checks++; if (busy2 !== 1'b1) begin n_fail++; $display("[TB] FAIL lanes_busy0: got %b expected 1", busy2); end
    tick();
    n_checks++; if (mat_we2 !== 2'b11) begin n_fail++; $display("[TB] FAIL lanes_we1: got %b expected 11", mat_we2); end
    n_checks++; if (mat_idx2 !== 4'b1110) begin n_fail++; $display("[TB] FAIL lanes_idx1: got %b expected 1110", mat_idx2); end
    n_checks++; if (mat_data2 !== {32'hB3, 32'hB2}) begin n_fail++; $display("[TB] FAIL lanes_data1: got %h expected b3/b2", mat_data2); end
    n_checks++; if (ready2 !== 1'b1) begin n_fail++; $display("[TB] FAIL lanes_ready1: got %b expected 1", ready2); end
    tick();
    n_checks++; if (mat_we2 !== 2'b00) begin n_fail++; $display("[TB] FAIL lanes_done: got %b expected 00", mat_we2); end
  endtask

  task automatic test_reset_mid_drain();
    wb_valid1 = 1; wb_mopa = 1;
    wb_matrix_mul_o = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    tick();
    idle_inputs();
    tick();
    n_checks++; if (mat_data1 !== 32'hC1) begin n_fail++; $display("[TB] FAIL mid_beat1: got %h expected c1", mat_data1); end
    rstn = 1'b0;
    #1;
    n_checks++; if (mat_we1 !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_we: got %b expected 0", mat_we1); end
    n_checks++; if (mat_data1 !== 32'h0) begin n_fail++; $display("[TB] FAIL mid_rst_data: got %h expected 0", mat_data1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_busy: got %b expected 0", busy1); end
    tick();
    n_checks++; if (mat_we1 !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_hold_we: got %b expected 0", mat_we1); end
    rstn = 1'b1;
    tick();
    n_checks++; if (mat_we1 !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_after_we: got %b expected 0", mat_we1); end
    n_checks++; if (ready1 !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_after_ready: got %b expected 1", ready1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_after_busy: got %b expected 0", busy1); end
    tick();
    n_checks++; if (mat_we1 !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_no_resume: got %b expected 0", mat_we1); end
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    test_reset();
    test_scalar_load();
    test_single_row();
    test_back_to_back();
    test_two_lanes();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
